// File: rtl/otter_mem_arbiter.sv
// Arbiter that shares one single-ported memory/IO bus between instruction fetch and the MEM stage.
// Data has priority over fetch, fetch starvation is bounded, and a stalled bus transaction is aborted with ERR.
module otter_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        IF_REQ,
    input  logic [31:0] IF_ADDR,
    output logic        IF_ACK,
    output logic        IF_ERR,
    output logic [31:0] IF_RDATA,
    input  logic        D_REQ,
    input  logic        D_WE,
    input  logic [31:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    input  logic [1:0]  D_SIZE,
    input  logic        D_SIGN,
    output logic        D_ACK,
    output logic        D_ERR,
    output logic [31:0] D_RDATA,
    output logic        M_REQ,
    output logic        M_WE,
    output logic [31:0] M_ADDR,
    output logic [31:0] M_WDATA,
    output logic [1:0]  M_SIZE,
    output logic        M_SIGN,
    input  logic        M_ACK,
    input  logic [31:0] M_RDATA,
    output logic        BUSY,
    output logic        OWNER_D
);

    // state | meaning
    // IDLE  | bus free, arbitrate between IF_REQ and D_REQ
    // WAIT  | command on the bus, waiting for M_ACK or timeout
    // RESP  | owner's ACK (and ERR) is high for this single cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  starve_cnt, starve_cnt_next;
    logic [9:0]  wait_cnt, wait_cnt_next;
    logic [10:0] wait_inc;
    logic        timed_out;
    logic        grant_d;

    logic        if_ack_n, if_err_n, d_ack_n, d_err_n;
    logic [31:0] if_rdata_n, d_rdata_n;
    logic        m_req_n, m_we_n, m_sign_n, owner_d_n, busy_n;
    logic [31:0] m_addr_n, m_wdata_n;
    logic [1:0]  m_size_n;

    // Abort at the end of the TIMEOUT-th WAIT cycle; wait_cnt holds the count of completed WAIT cycles.
    assign wait_inc  = {1'b0, wait_cnt} + 11'd1;
    assign timed_out = (TIMEOUT != 0) && (wait_inc >= 11'(TIMEOUT));
    assign grant_d   = D_REQ && !(IF_REQ && (starve_cnt == 4'(STARVE_MAX)));

    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        wait_cnt_next   = wait_cnt;
        if_ack_n        = 1'b0;
        if_err_n        = 1'b0;
        d_ack_n         = 1'b0;
        d_err_n         = 1'b0;
        if_rdata_n      = IF_RDATA;
        d_rdata_n       = D_RDATA;
        m_req_n         = M_REQ;
        m_we_n          = M_WE;
        m_addr_n        = M_ADDR;
        m_wdata_n       = M_WDATA;
        m_size_n        = M_SIZE;
        m_sign_n        = M_SIGN;
        owner_d_n       = OWNER_D;

        case (state)
            ST_IDLE: begin
                if (IF_REQ || D_REQ) begin
                    state_next    = ST_WAIT;
                    m_req_n       = 1'b1;
                    wait_cnt_next = 10'd0;
                    owner_d_n     = grant_d;
                    if (grant_d) begin
                        m_we_n    = D_WE;
                        m_addr_n  = D_ADDR;
                        m_wdata_n = D_WDATA;
                        m_size_n  = D_SIZE;
                        m_sign_n  = D_SIGN;
                        if (IF_REQ)
                            starve_cnt_next = starve_cnt + 4'd1;
                    end else begin
                        m_we_n          = 1'b0;
                        m_addr_n        = IF_ADDR;
                        m_wdata_n       = 32'd0;
                        m_size_n        = 2'd2;
                        m_sign_n        = 1'b0;
                        starve_cnt_next = 4'd0;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt != 10'h3FF)
                    wait_cnt_next = wait_cnt + 10'd1;
                if (M_ACK || timed_out) begin
                    state_next = ST_RESP;
                    m_req_n    = 1'b0;
                    if (OWNER_D) begin
                        d_ack_n   = 1'b1;
                        d_err_n   = !M_ACK;
                        d_rdata_n = (M_ACK && !M_WE) ? M_RDATA : 32'd0;
                    end else begin
                        if_ack_n   = 1'b1;
                        if_err_n   = !M_ACK;
                        if_rdata_n = M_ACK ? M_RDATA : 32'd0;
                    end
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        busy_n = (state_next != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state      <= ST_IDLE;
            starve_cnt <= 4'd0;
            wait_cnt   <= 10'd0;
            IF_ACK     <= 1'b0;
            IF_ERR     <= 1'b0;
            IF_RDATA   <= 32'd0;
            D_ACK      <= 1'b0;
            D_ERR      <= 1'b0;
            D_RDATA    <= 32'd0;
            M_REQ      <= 1'b0;
            M_WE       <= 1'b0;
            M_ADDR     <= 32'd0;
            M_WDATA    <= 32'd0;
            M_SIZE     <= 2'd0;
            M_SIGN     <= 1'b0;
            BUSY       <= 1'b0;
            OWNER_D    <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
            wait_cnt   <= wait_cnt_next;
            IF_ACK     <= if_ack_n;
            IF_ERR     <= if_err_n;
            IF_RDATA   <= if_rdata_n;
            D_ACK      <= d_ack_n;
            D_ERR      <= d_err_n;
            D_RDATA    <= d_rdata_n;
            M_REQ      <= m_req_n;
            M_WE       <= m_we_n;
            M_ADDR     <= m_addr_n;
            M_WDATA    <= m_wdata_n;
            M_SIZE     <= m_size_n;
            M_SIGN     <= m_sign_n;
            BUSY       <= busy_n;
            OWNER_D    <= owner_d_n;
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed bench for otter_mem_arbiter: a table of single transactions plus hand-written
// sequences for arbitration, starvation, timeout, reset mid-transaction and spurious bus ACKs.
module tb_otter_mem_arbiter;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 8;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IF_REQ = 1'b0;
    logic [31:0] IF_ADDR = '0;
    logic        IF_ACK, IF_ERR;
    logic [31:0] IF_RDATA;
    logic        D_REQ = 1'b0, D_WE = 1'b0, D_SIGN = 1'b0;
    logic [31:0] D_ADDR = '0, D_WDATA = '0;
    logic [1:0]  D_SIZE = '0;
    logic        D_ACK, D_ERR;
    logic [31:0] D_RDATA;
    logic        M_REQ, M_WE, M_SIGN;
    logic [31:0] M_ADDR, M_WDATA;
    logic [1:0]  M_SIZE;
    logic        M_ACK = 1'b0;
    logic [31:0] M_RDATA = '0;
    logic        BUSY, OWNER_D;

    otter_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_ERR(IF_ERR), .IF_RDATA(IF_RDATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA), .D_SIZE(D_SIZE),
        .D_SIGN(D_SIGN), .D_ACK(D_ACK), .D_ERR(D_ERR), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_WE(M_WE), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_SIZE(M_SIZE),
        .M_SIGN(M_SIGN), .M_ACK(M_ACK), .M_RDATA(M_RDATA), .BUSY(BUSY), .OWNER_D(OWNER_D)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        int          lat;
        logic [31:0] mrdata;
        logic        exp_we;
        logic [1:0]  exp_size;
        logic        exp_sign;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered at the negedge of an IDLE cycle (cycle 0); returns at the negedge of the next IDLE cycle.
    task automatic apply_vec(input string nm, input vec_t v);
        int cyc;
        D_WE = v.we; D_ADDR = v.addr; D_WDATA = v.wdata; D_SIZE = v.size; D_SIGN = v.sign;
        if (v.is_d) D_REQ = 1'b1;
        else begin IF_REQ = 1'b1; IF_ADDR = v.addr; end
        @(negedge CLK);
        check({nm, "_mreq"},  M_REQ, 1'b1);
        check({nm, "_busy"},  BUSY, 1'b1);
        check({nm, "_owner"}, OWNER_D, v.is_d);
        check({nm, "_addr"},  M_ADDR, v.addr);
        check({nm, "_we"},    M_WE, v.exp_we);
        check({nm, "_size"},  M_SIZE, v.exp_size);
        check({nm, "_sign"},  M_SIGN, v.exp_sign);
        check({nm, "_wdata"}, M_WDATA, v.exp_wdata);
        cyc = 1;
        while (cyc < v.lat) begin
            @(negedge CLK);
            cyc++;
        end
        check({nm, "_mreq_held"}, M_REQ, 1'b1);
        check({nm, "_ack_early"}, {IF_ACK, D_ACK}, 2'b00);
        M_ACK = 1'b1; M_RDATA = v.mrdata;
        @(negedge CLK);
        M_ACK = 1'b0; M_RDATA = 32'hBAD0_BAD0;
        check({nm, "_mreq_drop"}, M_REQ, 1'b0);
        check({nm, "_acks"}, {IF_ACK, D_ACK}, v.is_d ? 2'b01 : 2'b10);
        check({nm, "_errs"}, {IF_ERR, D_ERR}, 2'b00);
        check({nm, "_rdata"}, v.is_d ? D_RDATA : IF_RDATA, v.exp_rdata);
        IF_REQ = 1'b0; D_REQ = 1'b0;
        @(negedge CLK);
        check({nm, "_idle"}, {BUSY, IF_ACK, D_ACK}, 3'b000);
    endtask

    initial begin
        int  cnt;
        bit  ok;
        logic exp_d;

        //           is_d we  addr           wdata          sz sg lat mrdata         ewe esz esg ewdata         erdata
        vecs[0] = '{1'b0,1'b1,32'h0000_0100,32'hFFFF_0000,2'd0,1'b1,1,32'h0000_0013,1'b0,2'd2,1'b0,32'h0,        32'h0000_0013};
        vecs[1] = '{1'b1,1'b0,32'h0000_2000,32'hCAFE_F00D,2'd2,1'b0,2,32'h1234_5678,1'b0,2'd2,1'b0,32'hCAFE_F00D,32'h1234_5678};
        vecs[2] = '{1'b1,1'b1,32'h1100_0000,32'h0000_00A5,2'd0,1'b0,2,32'hFFFF_FFFF,1'b1,2'd0,1'b0,32'h0000_00A5,32'h0};
        vecs[3] = '{1'b1,1'b0,32'h0000_3002,32'h0,        2'd1,1'b1,3,32'h0000_BEEF,1'b0,2'd1,1'b1,32'h0,        32'h0000_BEEF};
        vecs[4] = '{1'b0,1'b1,32'h0000_0104,32'h0000_1111,2'd1,1'b1,4,32'h0050_0093,1'b0,2'd2,1'b0,32'h0,        32'h0050_0093};
        vecs[5] = '{1'b1,1'b1,32'h0000_6000,32'h5A5A_5A5A,2'd2,1'b0,7,32'h0000_0001,1'b1,2'd2,1'b0,32'h5A5A_5A5A,32'h0};
        vecs[6] = '{1'b1,1'b0,32'h0000_7000,32'h0,        2'd2,1'b0,8,32'h8765_4321,1'b0,2'd2,1'b0,32'h0,        32'h8765_4321};
        vecs[7] = '{1'b1,1'b0,32'h0000_8000,32'h0,        2'd2,1'b0,6,32'hDEAD_BEEF,1'b0,2'd2,1'b0,32'h0,        32'hDEAD_BEEF};

        repeat (3) @(negedge CLK);
        check("rst_ctrl", {BUSY, M_REQ, IF_ACK, D_ACK, IF_ERR, D_ERR, OWNER_D}, 7'd0);
        check("rst_m_size", M_SIZE, 2'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 7; i++)
            apply_vec($sformatf("vec%0d", i), vecs[i]);

        // Bus never acknowledges: abort after TIMEOUT WAIT cycles, late M_ACK ignored.
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_4000; D_SIZE = 2'd2; D_SIGN = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (M_REQ) cnt++;
            else break;
        end
        check("to_mreq_cycles", cnt, TIMEOUT);
        check("to_d_ack", D_ACK, 1'b1);
        check("to_d_err", D_ERR, 1'b1);
        check("to_d_rdata", D_RDATA, 32'h0);
        check("to_if_ack", {IF_ACK, IF_ERR}, 2'b00);
        D_REQ = 1'b0; M_ACK = 1'b1; M_RDATA = 32'h0000_0055;
        @(negedge CLK);
        check("to_late_ack1", {D_ACK, D_ERR, IF_ACK}, 3'b000);
        @(negedge CLK);
        M_ACK = 1'b0;
        check("to_late_ack2", {BUSY, M_REQ, D_ACK, IF_ACK}, 4'b0000);

        // Simultaneous requests: data store first, fetch in the following grant.
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0200;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 32'h1100_0000; D_WDATA = 32'hA5; D_SIZE = 2'd0; D_SIGN = 1'b0;
        @(negedge CLK);
        check("both_owner_d", OWNER_D, 1'b1);
        check("both_d_cmd", {M_WE, M_SIZE}, 3'b100);
        check("both_d_addr", M_ADDR, 32'h1100_0000);
        @(negedge CLK);
        check("both_d_mreq2", M_REQ, 1'b1);
        M_ACK = 1'b1; M_RDATA = 32'hFFFF_FFFF;
        @(negedge CLK);
        M_ACK = 1'b0;
        check("both_d_ack", {IF_ACK, D_ACK, D_ERR}, 3'b010);
        check("both_d_rdata", D_RDATA, 32'h0);
        D_REQ = 1'b0;
        @(negedge CLK);
        check("both_idle", {BUSY, M_REQ}, 2'b00);
        @(negedge CLK);
        check("both_f_mreq", M_REQ, 1'b1);
        check("both_f_owner", OWNER_D, 1'b0);
        check("both_f_addr", M_ADDR, 32'h0000_0200);
        check("both_f_cmd", {M_WE, M_SIZE, M_SIGN}, 4'b0100);
        M_ACK = 1'b1; M_RDATA = 32'h00A0_0093;
        @(negedge CLK);
        M_ACK = 1'b0;
        check("both_f_ack", {IF_ACK, IF_ERR, D_ACK}, 3'b100);
        check("both_f_rdata", IF_RDATA, 32'h00A0_0093);
        IF_REQ = 1'b0;
        @(negedge CLK);

        // Starvation bound: both requesters keep asking; fetch gets every fifth grant.
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0300;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 32'h0000_5000; D_SIZE = 2'd2;
        for (int g = 0; g < 10; g++) begin
            ok = 1'b0;
            for (int c = 0; c < 8 && !ok; c++) begin
                @(negedge CLK);
                if (M_REQ) ok = 1'b1;
            end
            check($sformatf("starve_grant%0d_seen", g), ok, 1'b1);
            exp_d = (g % 5) != 4;
            check($sformatf("starve_grant%0d_owner", g), OWNER_D, exp_d);
            M_ACK = 1'b1; M_RDATA = 32'(g);
            @(negedge CLK);
            M_ACK = 1'b0;
            check($sformatf("starve_grant%0d_ack", g), {IF_ACK, D_ACK}, exp_d ? 2'b01 : 2'b10);
            if (D_ACK) D_REQ = 1'b0;
            if (IF_ACK) IF_REQ = 1'b0;
            @(negedge CLK);
            if (g < 9) begin D_REQ = 1'b1; IF_REQ = 1'b1; end
        end
        D_REQ = 1'b0; IF_REQ = 1'b0;

        // Spurious M_ACK while idle, then a load with M_ACK five cycles after M_REQ rises.
        M_ACK = 1'b1; M_RDATA = 32'h0000_1234;
        @(negedge CLK);
        M_ACK = 1'b0;
        check("spur_ignored", {BUSY, M_REQ, IF_ACK, D_ACK}, 4'b0000);
        apply_vec("lat6", vecs[7]);

        // Reset in the middle of WAIT abandons the transaction.
        IF_REQ = 1'b1; IF_ADDR = 32'h0000_0400;
        @(negedge CLK);
        check("rw_mreq", M_REQ, 1'b1);
        @(negedge CLK);
        RESET_N = 1'b0; IF_REQ = 1'b0;
        @(negedge CLK);
        check("rw_ctrl", {M_REQ, BUSY, IF_ACK, D_ACK, OWNER_D}, 5'd0);
        check("rw_m_addr", M_ADDR, 32'h0);
        check("rw_d_rdata", D_RDATA, 32'h0);
        RESET_N = 1'b1; M_ACK = 1'b1;
        @(negedge CLK);
        M_ACK = 1'b0;
        check("rw_no_ack", {IF_ACK, D_ACK, BUSY}, 3'b000);
        apply_vec("after_rst", vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
